// File: rtl/vend_pkg.sv
// Shared coin encoding, coin values and FSM state type for the vending controller.
package vend_pkg;

   typedef logic [1:0] coin_code_t;

   localparam coin_code_t COIN_NONE    = 2'b00;
   localparam coin_code_t COIN_NICKEL  = 2'b01;
   localparam coin_code_t COIN_DIME    = 2'b10;
   localparam coin_code_t COIN_QUARTER = 2'b11;

   localparam logic [6:0] VAL_NICKEL  = 7'd5;
   localparam logic [6:0] VAL_DIME    = 7'd10;
   localparam logic [6:0] VAL_QUARTER = 7'd25;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2,
      ST_CHANGE  = 2'd3
   } state_t;

   function automatic logic [6:0] coin_value(input coin_code_t code);
      case (code)
         COIN_NICKEL:  coin_value = VAL_NICKEL;
         COIN_DIME:    coin_value = VAL_DIME;
         COIN_QUARTER: coin_value = VAL_QUARTER;
         default:      coin_value = 7'd0;
      endcase
   endfunction

endpackage

// File: rtl/change_picker.sv
// Chooses the largest change coin that fits in the given credit; none when credit is 0.
module change_picker
   import vend_pkg::*;
(
   input  logic [6:0] credit,
   output coin_code_t code,
   output logic [6:0] value
);

   always_comb begin
      code = COIN_NONE;
      if (credit >= VAL_QUARTER) begin
         code = COIN_QUARTER;
      end else if (credit >= VAL_DIME) begin
         code = COIN_DIME;
      end else if (credit != 7'd0) begin
         code = COIN_NICKEL;
      end
      value = coin_value(code);
   end

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending FSM: collects credit, vends one item, pays change largest coin first.
module vend_controller
   import vend_pkg::*;
#(
   parameter int PRICE      = 35,
   parameter int CREDIT_MAX = 95
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_code,
   input  logic       buy,
   input  logic       cancel,
   output logic [6:0] credit,
   output logic       coin_reject,
   output logic       vend,
   output logic       change_valid,
   output logic [1:0] change_code,
   output logic       busy
);

   localparam logic [6:0] PRICE_C      = 7'(PRICE);
   localparam logic [7:0] CREDIT_MAX_C = 8'(CREDIT_MAX);

   state_t     state_reg, state_next;
   logic [6:0] credit_reg, credit_next;
   logic       reject_reg, reject_next;
   logic       vend_reg, busy_reg, change_valid_reg;
   coin_code_t change_code_reg;

   logic       coin_in;
   logic [7:0] coin_sum;
   logic [6:0] last_coin;
   coin_code_t pick_code;
   logic [6:0] pick_value;
   logic       emit_next;

   assign coin_in   = coin_valid && (coin_code != COIN_NONE);
   assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_value(coin_code)};
   assign last_coin = coin_value(change_code_reg);

   // Picks the coin to be shown alongside next cycle's credit, so a coin and the
   // credit it is taken from appear together and vend-to-first-coin is one cycle.
   change_picker u_picker (
      .credit (credit_next),
      .code   (pick_code),
      .value  (pick_value)
   );

   always_comb begin
      state_next  = state_reg;
      credit_next = credit_reg;
      reject_next = 1'b0;
      case (state_reg)
         ST_IDLE, ST_COLLECT: begin
            if (cancel && state_reg == ST_COLLECT) begin
               state_next = ST_CHANGE;
            end else if (coin_in) begin
               if (coin_sum <= CREDIT_MAX_C) begin
                  credit_next = coin_sum[6:0];
                  state_next  = ST_COLLECT;
               end else begin
                  reject_next = 1'b1;
               end
            end else if (buy && state_reg == ST_COLLECT && credit_reg >= PRICE_C) begin
               state_next = ST_VEND;
            end
         end
         ST_VEND: begin
            reject_next = coin_in;
            credit_next = (credit_reg >= PRICE_C) ? credit_reg - PRICE_C : 7'd0;
            state_next  = (credit_next != 7'd0) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            reject_next = coin_in;
            if (credit_reg == 7'd0) begin
               state_next = ST_IDLE;
            end else begin
               credit_next = (credit_reg >= last_coin) ? credit_reg - last_coin : 7'd0;
            end
         end
         default: begin
            state_next  = ST_IDLE;
            credit_next = 7'd0;
         end
      endcase
   end

   assign emit_next = (state_next == ST_CHANGE) && (credit_next != 7'd0) && (pick_value != 7'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         credit_reg       <= 7'd0;
         reject_reg       <= 1'b0;
         vend_reg         <= 1'b0;
         busy_reg         <= 1'b0;
         change_valid_reg <= 1'b0;
         change_code_reg  <= COIN_NONE;
      end else begin
         state_reg        <= state_next;
         credit_reg       <= credit_next;
         reject_reg       <= reject_next;
         vend_reg         <= (state_next == ST_VEND);
         busy_reg         <= (state_next == ST_VEND) || (state_next == ST_CHANGE);
         change_valid_reg <= emit_next;
         change_code_reg  <= emit_next ? pick_code : COIN_NONE;
      end
   end

   assign credit       = credit_reg;
   assign coin_reject  = reject_reg;
   assign vend         = vend_reg;
   assign change_valid = change_valid_reg;
   assign change_code  = change_code_reg;
   assign busy         = busy_reg;

endmodule
